// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared mode/state encodings for the universal shift register
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_ROR  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SER  = 1'b1
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - control/data bundle between the shift register and its driver
interface univ_shift_reg_if #(
    parameter int WIDTH = 4
);
    logic             load_n;
    logic [WIDTH-1:0] in;
    logic [1:0]       mode;
    logic             en;
    logic             ser_in;
    logic             start;
    logic [WIDTH-1:0] out;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output load_n, in, mode, en, ser_in, start,
        input  out, ser_out, busy, done
    );

    modport slave (
        input  load_n, in, mode, en, ser_in, start,
        output out, ser_out, busy, done
    );
endinterface

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - loadable down-counter that saturates at zero
module bit_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(WIDTH);
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with automatic LSB-first serialisation
module univ_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    univ_shift_reg_if.slave   bus
);
    import shift_reg_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   out_q;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;
    logic               cnt_load;
    logic               cnt_dec;
    logic               last_bit;

    bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .count (cnt),
        .zero  (cnt_zero)
    );

    assign last_bit = (state_q == ST_SER) && (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_SER;
                    cnt_load = 1'b1;
                end
            end
            ST_SER: begin
                cnt_dec = 1'b1;
                // The zero check only guards against a corrupted count.
                if (last_bit || cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else if (state_q == ST_SER) begin
            out_q <= {1'b0, out_q[WIDTH-1:1]};
        end else if (bus.start || !bus.load_n) begin
            out_q <= bus.in;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_SHL: out_q <= {out_q[WIDTH-2:0], bus.ser_in};
                MODE_SHR: out_q <= {bus.ser_in, out_q[WIDTH-1:1]};
                MODE_ROR: out_q <= {out_q[0], out_q[WIDTH-1:1]};
                default:  out_q <= out_q;
            endcase
        end
    end

    assign bus.out     = out_q;
    assign bus.busy    = (state_q == ST_SER);
    assign bus.done    = last_bit;
    // Left shifts present the MSB so a chain of registers shifts coherently.
    assign bus.ser_out = ((state_q == ST_IDLE) && (bus.mode == MODE_SHL)) ?
                         out_q[WIDTH-1] : out_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed vector bench for univ_shift_reg at WIDTH=4
module tb_univ_shift_reg;

    localparam int W = 4;

    typedef struct {
        logic         start;
        logic         load_n;
        logic [W-1:0] din;
        logic [1:0]   mode;
        logic         en;
        logic         ser_in;
        logic [W-1:0] exp_out;
        logic         exp_busy;
        logic         exp_done;
        logic         exp_ser;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[17];

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic ld_n, input logic [W-1:0] d,
                         input logic [1:0] m, input logic e, input logic si);
        bus.start  = st;
        bus.load_n = ld_n;
        bus.in     = d;
        bus.mode   = m;
        bus.en     = e;
        bus.ser_in = si;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] o, input logic b,
                           input logic dn, input logic so);
        chk({tag, ".out"},     32'(bus.out),     32'(o));
        chk({tag, ".busy"},    32'(bus.busy),    32'(b));
        chk({tag, ".done"},    32'(bus.done),    32'(dn));
        chk({tag, ".ser_out"}, 32'(bus.ser_out), 32'(so));
    endtask

    initial begin
        //           start ld_n din      mode   en   si    out      busy done ser
        vecs[0]  = '{1'b0, 1'b0, 4'b1011, 2'b00, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 4'b0000, 2'b01, 1'b1, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'b0000, 2'b01, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 4'b1001, 2'b00, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 4'b0000, 2'b11, 1'b1, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'b0000, 2'b11, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'b0000, 2'b11, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'b0000, 2'b11, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 4'b0000, 2'b10, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'b0000, 2'b10, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'b1010, 2'b01, 1'b1, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'b0110, 2'b01, 1'b1, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 4'b0110, 2'b01, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'b0110, 2'b11, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].start, vecs[i].load_n, vecs[i].din, vecs[i].mode,
                  vecs[i].en, vecs[i].ser_in);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy,
                    vecs[i].exp_done, vecs[i].exp_ser);
        end

        // Serialise 1101 LSB-first, holding start high into the last SER cycle.
        drive(1'b1, 1'b1, 4'b1101, 2'b00, 1'b0, 1'b0);
        step();
        chk_all("ser1", 4'b1101, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        step();
        chk_all("ser2", 4'b0110, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("ser3", 4'b0011, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'b0111, 2'b00, 1'b0, 1'b0);
        step();
        chk_all("ser4", 4'b0001, 1'b1, 1'b1, 1'b1);
        step();
        chk_all("ser_end", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("restart", 4'b0111, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        step();
        chk_all("restart2", 4'b0011, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a serialisation.
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'b0110, 2'b00, 1'b0, 1'b0);
        step();
        chk_all("post_rst_load", 4'b0110, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("no_done%0d", i), 32'(bus.done), 32'd0);
            chk($sformatf("no_busy%0d", i), 32'(bus.busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 load_n  input  1  active-low parallel load request.
REQ-005 in  input  WIDTH  parallel load data.
REQ-006 mode  input  2  idle-time operation: 00 hold, 01 shift left, 10 shift right, 11 rotate right.
REQ-007 en  input  1  qualifies mode shift/rotate operations.
REQ-008 ser_in  input  1  serial fill bit for shifts.
REQ-009 start  input  1  request automatic serialisation of in.
REQ-010 out  output  WIDTH  register contents.
REQ-011 ser_out  output  1  serial output bit.
REQ-012 busy  output  1  high while automatic serialisation runs.
REQ-013 done  output  1  one-cycle pulse at serialisation end.

Function
REQ-014 FSM shall have two states: IDLE and SER.
REQ-015 IDLE priority, highest first: start, then load_n==0, then en with mode, else hold.
REQ-016 IDLE, start=1: out <= in, counter <= WIDTH, next state SER, regardless of load_n/en.
REQ-017 IDLE, start=0, load_n=0: out <= in next edge.
REQ-018 IDLE, en=1, mode 01: out <= {out[WIDTH-2:0], ser_in}.
REQ-019 IDLE, en=1, mode 10: out <= {ser_in, out[WIDTH-1:1]}.
REQ-020 IDLE, en=1, mode 11: out <= {out[0], out[WIDTH-1:1]}.
REQ-021 IDLE, en=0 or mode 00: out holds.
REQ-022 SER: each cycle out <= {1'b0, out[WIDTH-1:1]}, counter decrements; start, load_n, en, mode, ser_in ignored.
REQ-023 SER with counter==1: final shift, done=1 for that cycle, next state IDLE.
REQ-024 busy shall be 1 exactly in SER (combinational from state); WIDTH cycles per serialisation.
REQ-025 ser_out shall be out[WIDTH-1] when in IDLE with mode 01, else out[0] (LSB-first in SER).
REQ-026 done shall be combinational from state and counter, never high in IDLE.
REQ-027 Counter width shall be $clog2(WIDTH+1); no wrap below 1 allowed.
REQ-028 start held high through end of SER shall start a new serialisation on the first IDLE cycle.

Reset
REQ-029 rst=1 shall immediately force out=0, counter=0, state IDLE; busy=0, done=0, ser_out=0.
REQ-030 rst asserted mid-SER shall abort serialisation with no done pulse.
REQ-031 After rst deassertion, first edge shall evaluate IDLE priority normally.

Structure
REQ-032 Mode encodings (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROR) and state encodings shall live in shared package shift_reg_pkg.
REQ-033 Down-counter shall be sub-module bit_counter (parameter WIDTH, load, decrement, zero flag); datapath and FSM stay in univ_shift_reg.

Verification (WIDTH=4)
REQ-034 rst pulse mid-operation -> out=0000, busy=0, done=0 same cycle, no later done.
REQ-035 load_n=0, in=1011, then mode=01, en=1, ser_in=1 for 2 cycles -> out 1011, 0111, 1111.
REQ-036 out=1001, mode=11, en=1 for 4 cycles -> 1100, 0110, 0011, 1001.
REQ-037 start=1, in=1101 -> busy 4 cycles, ser_out 1,0,1,1 LSB-first, done on 4th SER cycle, out=0000 after.
REQ-038 load_n=0, in=0110 during SER -> ignored; out continues shifting zeros.
REQ-039 start and load_n=0 same IDLE cycle, in=1010 -> SER entered, out=1010, busy=1.
